// File: rtl/swcap_pkg.sv
// Shared types and defaults for the switched-capacitor bank controller.
// Optional feature macro used by the controller: SWCAP_DITHER_EN.
package swcap_pkg;

  localparam int NCAP_DEF    = 16;
  localparam int CODE_W_DEF  = 5;
  localparam int DWELL_W_DEF = 4;

  // Walk controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP  = 2'd1,
    ST_DWELL = 2'd2
  } state_e;

  // Saturate a requested cell count to the number of physical cells.
  function automatic logic [31:0] clamp_code(input logic [31:0] code, input logic [31:0] ncap);
    logic [31:0] res;
    if (code > ncap) begin
      res = ncap;
    end else begin
      res = code;
    end
    return res;
  endfunction

endpackage

// File: rtl/swcap_therm_dec.sv
// Combinational binary-to-thermometer decoder: bit i is set when i < code_i.
module swcap_therm_dec
  import swcap_pkg::*;
#(
  parameter int NCAP   = NCAP_DEF,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic [CODE_W-1:0] code_i,
  output logic [NCAP-1:0]   therm_o
);

  // Set every cell index strictly below the code.
  always_comb begin
    therm_o = {NCAP{1'b0}};
    for (int i = 0; i < NCAP; i++) begin
      if (int'(code_i) > i) begin
        therm_o[i] = 1'b1;
      end else begin
        therm_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/swcap_bank_ctrl.sv
// Switched-capacitor bank tuning controller. Accepts a binary cell count and
// walks the thermometer switch vector toward it one cell per step, with a
// programmable dwell between steps so the DCO never jumps more than one LSB.
// Optional macro SWCAP_DITHER_EN adds dither_i: in IDLE the next cell above
// cur toggles every clock for half-LSB average tuning.
module swcap_bank_ctrl
  import swcap_pkg::*;
#(
  parameter int NCAP    = NCAP_DEF,
  parameter int CODE_W  = CODE_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CODE_W-1:0]  code_i,
  input  logic               code_valid_i,
  output logic               code_ready_o,
  input  logic [DWELL_W-1:0] dwell_i,
`ifdef SWCAP_DITHER_EN
  input  logic               dither_i,
`endif
  output logic [NCAP-1:0]    sw_o,
  output logic [CODE_W-1:0]  cur_code_o,
  output logic               busy_o,
  output logic               clamp_o
);

  localparam logic [CODE_W-1:0] NCAP_C = CODE_W'(NCAP);

  state_e             state_q, state_d;
  logic [CODE_W-1:0]  cur_q, cur_d;
  logic [CODE_W-1:0]  tgt_q, tgt_d;
  logic [DWELL_W-1:0] dw_q, dw_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               clamp_q, clamp_d;
  logic               ready_q, ready_d;
  logic [NCAP-1:0]    sw_q, sw_d;
  logic [NCAP-1:0]    therm_s;
  logic [CODE_W-1:0]  code_clamped_s;
`ifdef SWCAP_DITHER_EN
  logic               dith_q, dith_d;
`endif

  assign code_clamped_s = CODE_W'(clamp_code(32'(code_i), 32'(NCAP)));

  // Decode the next cell count so sw_q lands on the same edge as cur_q.
  swcap_therm_dec #(
    .NCAP   (NCAP),
    .CODE_W (CODE_W)
  ) u_therm_dec (
    .code_i  (cur_d),
    .therm_o (therm_s)
  );

  // Walk FSM: accept in IDLE, one cell per STEP, dwell countdown in DWELL.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    dw_d    = dw_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    clamp_d = clamp_q;
    case (state_q)
      ST_IDLE: begin
        if (code_valid_i) begin
          tgt_d   = code_clamped_s;
          clamp_d = (code_i > NCAP_C);
          dw_d    = dwell_i;
          if (code_clamped_s != cur_q) begin
            state_d = ST_STEP;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (cur_q < tgt_q) begin
          cur_d = cur_q + CODE_W'(1);
        end else if (cur_q > tgt_q) begin
          cur_d = cur_q - CODE_W'(1);
        end else begin
          cur_d = cur_q;
        end
        if (cur_d == tgt_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (dw_q == {DWELL_W{1'b0}}) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_DWELL;
          cnt_d   = dw_q;
        end
      end
      ST_DWELL: begin
        cnt_d = cnt_q - DWELL_W'(1);
        if (cnt_q <= DWELL_W'(1)) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_DWELL;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // Switch vector: thermometer of the next count, plus the dither cell when enabled.
  always_comb begin
`ifdef SWCAP_DITHER_EN
    dith_d = 1'b0;
    if ((state_q == ST_IDLE) && (state_d == ST_IDLE) && dither_i && (cur_q < NCAP_C)) begin
      dith_d = ~dith_q;
    end else begin
      dith_d = 1'b0;
    end
    if (dith_d) begin
      sw_d = therm_s | (NCAP'(1'b1) << cur_q);
    end else begin
      sw_d = therm_s;
    end
`else
    sw_d = therm_s;
`endif
  end

  // State and output registers; all clear asynchronously, no resume after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cur_q   <= {CODE_W{1'b0}};
      tgt_q   <= {CODE_W{1'b0}};
      dw_q    <= {DWELL_W{1'b0}};
      cnt_q   <= {DWELL_W{1'b0}};
      busy_q  <= 1'b0;
      clamp_q <= 1'b0;
      ready_q <= 1'b1;
      sw_q    <= {NCAP{1'b0}};
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      dw_q    <= dw_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      clamp_q <= clamp_d;
      ready_q <= ready_d;
      sw_q    <= sw_d;
    end
  end

`ifdef SWCAP_DITHER_EN
  // Dither phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dith_q <= 1'b0;
    end else begin
      dith_q <= dith_d;
    end
  end
`endif

  assign sw_o         = sw_q;
  assign cur_code_o   = cur_q;
  assign busy_o       = busy_q;
  assign clamp_o      = clamp_q;
  assign code_ready_o = ready_q;

endmodule
